// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB configuration loader.
//   CFG_W       : width of one CLB confi word
//   SYNC_WORD   : frame header, sent MSB-first before every payload
//   *_LSB/*_W   : confi field placement (MODE, SEL_A, SEL_B, ROUTE, USE_FF)
//   cfg_state_e : loader FSM states
//   confi_t     : packed view of one confi word
package clb_cfg_pkg;

    localparam int unsigned CFG_W     = 13;
    localparam int unsigned HDR_W     = 8;
    localparam logic [7:0]  SYNC_WORD = 8'hA5;

    localparam int unsigned MODE_LSB   = 0;
    localparam int unsigned MODE_W     = 2;
    localparam int unsigned SEL_A_LSB  = 2;
    localparam int unsigned SEL_A_W    = 3;
    localparam int unsigned SEL_B_LSB  = 5;
    localparam int unsigned SEL_B_W    = 3;
    localparam int unsigned ROUTE_LSB  = 8;
    localparam int unsigned ROUTE_W    = 4;
    localparam int unsigned USE_FF_LSB = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        LOAD   = 3'd2,
        PAR    = 3'd3,
        COMMIT = 3'd4
    } cfg_state_e;

    // Field order mirrors the *_LSB offsets above, MSB first.
    typedef struct packed {
        logic                 use_ff;
        logic [ROUTE_W-1:0]   route;
        logic [SEL_B_W-1:0]   sel_b;
        logic [SEL_A_W-1:0]   sel_a;
        logic [MODE_W-1:0]    mode;
    } confi_t;

endpackage

// File: rtl/clb_cfg_loader_if.sv
// Serial configuration bit channel (valid/ready).
//   bit_valid_i : producer offers a bit
//   bit_data_i  : bit value
//   bit_ready_o : loader takes the bit this cycle
// master = bitstream source, slave = clb_cfg_loader.
interface clb_cfg_loader_if;

    logic bit_valid_i;
    logic bit_data_i;
    logic bit_ready_o;

    modport master (
        output bit_valid_i,
        output bit_data_i,
        input  bit_ready_o
    );

    modport slave (
        input  bit_valid_i,
        input  bit_data_i,
        output bit_ready_o
    );

endinterface

// File: rtl/clb_cfg_loader.sv
// Frames a serial config bitstream (sync header, payload, even parity) and
// commits one confi word per CLB in a single cycle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : begin a load (IDLE only)
//   abort_i      : cancel a load in HDR/LOAD/PAR
//   bit_if       : serial bit channel (slave side)
//   cfg_o        : committed config, CLB n at [n*CFG_W +: CFG_W]
//   cfg_valid_o  : sticky, set by the first successful commit
//   busy_o       : FSM not in IDLE
//   done_o       : one-cycle pulse, first cycle of new cfg_o
//   err_o        : one-cycle pulse on header or parity failure
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int unsigned NUM_CLB = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    clb_cfg_loader_if.slave          bit_if,
    output logic [NUM_CLB*CFG_W-1:0] cfg_o,
    output logic                     cfg_valid_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int unsigned PAY_W = NUM_CLB * CFG_W;
    localparam int unsigned CNT_W = $clog2(PAY_W + 1);

    cfg_state_e         r_state;
    cfg_state_e         w_state_nxt;
    logic [HDR_W-2:0]   r_hdr_sr;      // last 7 header bits; the 8th is compared live
    logic [2:0]         r_hdr_cnt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_par;
    logic [PAY_W-1:0]   r_shadow;
    logic               r_cfg_valid;
    logic               r_done;
    logic               r_err;

    logic               w_ready;
    logic               w_accept;
    logic               w_commit;
    logic               w_err_nxt;
    logic               w_hdr_ok;
    logic               w_par_ok;

    assign w_hdr_ok = ({r_hdr_sr, bit_if.bit_data_i} == SYNC_WORD);
    assign w_par_ok = ~(r_par ^ bit_if.bit_data_i);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake and pulse requests
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_err_nxt   = 1'b0;
        w_ready     = ((r_state == HDR) || (r_state == LOAD) || (r_state == PAR)) && !abort_i;
        w_accept    = bit_if.bit_valid_i && w_ready;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_accept && (r_hdr_cnt == 3'd7)) begin
                    w_state_nxt = w_hdr_ok ? LOAD : IDLE;
                    w_err_nxt   = !w_hdr_ok;
                end
            end
            LOAD: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_accept && (r_bit_cnt == CNT_W'(PAY_W - 1))) begin
                    w_state_nxt = PAR;
                end
            end
            PAR: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_accept) begin
                    w_state_nxt = w_par_ok ? COMMIT : IDLE;
                    w_err_nxt   = !w_par_ok;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Header shift, payload shadow, counters, parity and status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hdr_sr    <= '0;
            r_hdr_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_par       <= 1'b0;
            r_shadow    <= '0;
            r_cfg_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_err  <= w_err_nxt;
            if (w_commit) begin
                r_cfg_valid <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_hdr_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_par     <= 1'b0;
                    end
                end
                HDR: begin
                    if (w_accept) begin
                        r_hdr_sr <= {r_hdr_sr[HDR_W-3:0], bit_if.bit_data_i};
                        if (r_hdr_cnt != 3'd7) begin
                            r_hdr_cnt <= r_hdr_cnt + 3'd1;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_shadow[r_bit_cnt] <= bit_if.bit_data_i;
                        r_par               <= r_par ^ bit_if.bit_data_i;
                        r_bit_cnt           <= r_bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Per-CLB committed word, loaded from its shadow slice at COMMIT
    for (genvar n = 0; n < NUM_CLB; n++) begin : g_clb
        confi_t r_word;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_word <= '0;
            end else if (w_commit) begin
                r_word <= confi_t'(r_shadow[n*CFG_W +: CFG_W]);
            end
        end

        assign cfg_o[n*CFG_W +: CFG_W] = r_word;
    end

    assign bit_if.bit_ready_o = w_ready;
    assign cfg_valid_o        = r_cfg_valid;
    assign busy_o             = (r_state != IDLE);
    assign done_o             = r_done;
    assign err_o              = r_err;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Self-checking bench for clb_cfg_loader with NUM_CLB=2; commit/error pulses
// are matched against a queue of expected outcomes.
module tb_clb_cfg_loader;
    import clb_cfg_pkg::*;

    localparam int unsigned NCLB = 2;
    localparam int unsigned PW   = NCLB * CFG_W;

    typedef struct packed {
        logic          is_done;
        logic          valid;
        logic [PW-1:0] cfg;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] cfg;
    logic          cfg_valid;
    logic          busy;
    logic          done;
    logic          err;

    clb_cfg_loader_if bus();

    clb_cfg_loader #(.NUM_CLB(NCLB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .bit_if      (bus),
        .cfg_o       (cfg),
        .cfg_valid_o (cfg_valid),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int            n_total = 0;
    int            n_bad   = 0;
    int            n_pulse = 0;
    int            n_exp   = 0;
    exp_t          sb_q[$];
    exp_t          mon_e;
    bit            stream_q[$];
    logic [PW-1:0] m_cfg   = '0;
    logic          m_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk(input int unsigned mode, input int unsigned sel_a,
                                            input int unsigned sel_b, input int unsigned route,
                                            input int unsigned use_ff);
        return CFG_W'((mode << MODE_LSB) | (sel_a << SEL_A_LSB) | (sel_b << SEL_B_LSB) |
                      (route << ROUTE_LSB) | (use_ff << USE_FF_LSB));
    endfunction

    // Scoreboard: every done/err pulse consumes one expected outcome
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            n_pulse++;
            check("pulse_excl", 64'(done && err), 64'd0);
            if (sb_q.size() == 0) begin
                check("sb_depth", 64'(sb_q.size()), 64'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_kind",  64'(done), 64'(mon_e.is_done));
                check("sb_clb0",  64'(cfg[CFG_W-1:0]), 64'(mon_e.cfg[CFG_W-1:0]));
                check("sb_clb1",  64'(cfg[PW-1:CFG_W]), 64'(mon_e.cfg[PW-1:CFG_W]));
                check("sb_valid", 64'(cfg_valid), 64'(mon_e.valid));
            end
        end
    end

    task automatic expect_pulse(input logic is_done, input logic [PW-1:0] c, input logic v);
        exp_t e;
        e.is_done = is_done;
        e.valid   = v;
        e.cfg     = c;
        sb_q.push_back(e);
        n_exp++;
    endtask

    task automatic build(input logic [7:0] hdr, input logic [PW-1:0] pay,
                         input bit good_par, input bit hdr_only);
        stream_q.delete();
        for (int i = 7; i >= 0; i--) stream_q.push_back(hdr[i]);
        if (!hdr_only) begin
            for (int k = 0; k < int'(PW); k++) stream_q.push_back(pay[k]);
            stream_q.push_back(good_par ? (^pay) : ~(^pay));
        end
    endtask

    // Offers stream bits; at index cut_at, aborts (or resets) instead of sending.
    task automatic send_stream(input bit thr, input int cut_at, input bit use_rst);
        bit   got;
        int   budget;
        logic v;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (i == cut_at) begin
                @(negedge clk);
                if (use_rst) rst = 1'b1;
                else         abort = 1'b1;
                bus.bit_valid_i = 1'b1;
                bus.bit_data_i  = stream_q[i];
                #1;
                if (!use_rst) check("abort_rdy", 64'(bus.bit_ready_o), 64'd0);
                @(negedge clk);
                rst   = 1'b0;
                abort = 1'b0;
                bus.bit_valid_i = 1'b0;
                return;
            end
            got    = 1'b0;
            budget = 0;
            while (!got) begin
                @(negedge clk);
                v = thr ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.bit_valid_i = v;
                bus.bit_data_i  = stream_q[i];
                #1;
                if (thr) check("thr_rdy", 64'(bus.bit_ready_o), 64'd1);
                got = v && bus.bit_ready_o;
                budget++;
                if (budget > 50) begin
                    check("bit_timeout", 64'(budget), 64'd50);
                    bus.bit_valid_i = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_hdr", 64'(busy), 64'd1);
    endtask

    task automatic run_good(input logic [PW-1:0] pay, input bit thr, input bit skip_start);
        if (!skip_start) do_start();
        build(SYNC_WORD, pay, 1'b1, 1'b0);
        expect_pulse(1'b1, pay, 1'b1);
        send_stream(thr, -1, 1'b0);
        @(negedge clk);
        bus.bit_valid_i = 1'b0;
        check("commit_busy", 64'(busy), 64'd1);
        check("commit_done0", 64'(done), 64'd0);
        check("commit_cfg_old", 64'(cfg), 64'(m_cfg));
        @(negedge clk);
        check("commit_done1", 64'(done), 64'd1);
        check("commit_idle", 64'(busy), 64'd0);
        m_cfg   = pay;
        m_valid = 1'b1;
    endtask

    logic [PW-1:0] pay_a, pay_b, pay_c, pay_d;

    initial begin
        bus.bit_valid_i = 1'b1;
        bus.bit_data_i  = 1'b0;
        pay_a = {13'h1FFF, mk(0, 4, 5, 1, 0)};
        pay_b = {13'h0A5A, 13'h1234};
        pay_c = {13'h0ABC, 13'h0000};
        pay_d = {13'h1001, 13'h0FFE};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cfg",   64'(cfg), 64'd0);
        check("rst_valid", 64'(cfg_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_rdy",   64'(bus.bit_ready_o), 64'd0);
        rst = 1'b0;
        bus.bit_valid_i = 1'b0;

        // Bad parity after reset
        do_start();
        build(SYNC_WORD, pay_a, 1'b0, 1'b0);
        expect_pulse(1'b0, m_cfg, m_valid);
        send_stream(1'b0, -1, 1'b0);
        @(negedge clk);
        bus.bit_valid_i = 1'b0;
        check("par_err",  64'(err), 64'd1);
        check("par_busy", 64'(busy), 64'd0);
        check("par_done", 64'(done), 64'd0);

        // Bad header
        do_start();
        build(8'hA4, pay_a, 1'b1, 1'b1);
        expect_pulse(1'b0, m_cfg, m_valid);
        send_stream(1'b0, -1, 1'b0);
        @(negedge clk);
        bus.bit_valid_i = 1'b0;
        check("hdr_err",  64'(err), 64'd1);
        check("hdr_busy", 64'(busy), 64'd0);
        @(negedge clk);
        bus.bit_valid_i = 1'b1;
        #1;
        check("hdr_no_rdy", 64'(bus.bit_ready_o), 64'd0);
        @(negedge clk);
        bus.bit_valid_i = 1'b0;
        check("hdr_err_1cyc", 64'(err), 64'd0);
        check("hdr_cfg", 64'(cfg), 64'd0);

        // Good frame
        run_good(pay_a, 1'b0, 1'b0);

        // Abort at payload bit 10, then another good frame
        do_start();
        build(SYNC_WORD, pay_b, 1'b1, 1'b0);
        send_stream(1'b0, 8 + 10, 1'b0);
        check("abort_busy",  64'(busy), 64'd0);
        check("abort_done",  64'(done), 64'd0);
        check("abort_err",   64'(err), 64'd0);
        check("abort_cfg",   64'(cfg), 64'(m_cfg));
        check("abort_valid", 64'(cfg_valid), 64'(m_valid));
        @(negedge clk);
        check("abort_quiet", 64'(done || err), 64'd0);
        run_good(pay_b, 1'b0, 1'b0);

        // Throttled input, back to frame A
        run_good(pay_a, 1'b1, 1'b0);

        // Back-to-back with start held across done
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        run_good(pay_b, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        run_good(pay_c, 1'b0, 1'b1);
        check("b2b_clb0", 64'(cfg[CFG_W-1:0]), 64'd0);
        check("b2b_valid", 64'(cfg_valid), 64'd1);

        // Reset mid-LOAD
        do_start();
        build(SYNC_WORD, pay_d, 1'b1, 1'b0);
        send_stream(1'b0, 8 + 5, 1'b1);
        m_cfg   = '0;
        m_valid = 1'b0;
        check("mrst_cfg",   64'(cfg), 64'd0);
        check("mrst_valid", 64'(cfg_valid), 64'd0);
        check("mrst_busy",  64'(busy), 64'd0);
        check("mrst_pulse", 64'(done || err), 64'd0);
        run_good(pay_d, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("pulse_count", 64'(n_pulse), 64'(n_exp));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
